pipe_stage_buf: RTL and testbench
=================================

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 Parameter WIDTH, default 32, payload width in bits (>=1).
REQ-002 Parameter DEPTH, default 2, entry count (power of two, >=2).
REQ-003 Parameter RESET_VAL, default '0, WIDTH-bit value driven on out_data when no entry is valid.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 in_valid  input  1  upstream offers in_data this cycle.
REQ-007 in_ready  output  1  buffer can accept an entry this cycle.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 out_valid  output  1  head entry is presented on out_data.
REQ-010 out_ready  input  1  downstream consumes the head entry this cycle.
REQ-011 out_data  output  WIDTH  head-entry payload.
REQ-012 hold  input  1  stall: freezes the output side; no pop while high.
REQ-013 flush  input  1  synchronous discard of all entries.
REQ-014 count  output  $clog2(DEPTH+1)  number of valid entries.

Function
REQ-015 Push SHALL occur when in_valid && in_ready && !flush; pop SHALL occur when out_valid && out_ready && !hold && !flush.
REQ-016 in_ready SHALL equal (count < DEPTH) and SHALL NOT depend combinationally on out_ready, hold or flush.
REQ-017 out_valid SHALL equal (count != 0); out_data SHALL be the oldest entry when out_valid=1, else RESET_VAL.
REQ-018 Latency: an entry pushed at edge N SHALL be visible on out_data/out_valid immediately after edge N if the buffer was empty (1-cycle latency, no bypass).
REQ-019 Entries SHALL leave in push order (FIFO); payload SHALL never be modified.
REQ-020 count next = count + push - pop; simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-021 Read/write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH with no lost or duplicated entry at wrap.
REQ-022 Full (count=DEPTH): in_ready=0; in_valid is ignored even if a pop occurs the same cycle.
REQ-023 Empty (count=0): out_valid=0; out_ready and hold are ignored; count never underflows.
REQ-024 hold=1 SHALL keep out_valid, out_data and the read pointer stable; pushes continue while in_ready=1.
REQ-025 flush=1 at edge N SHALL set count=0 and both pointers to 0 after edge N; a same-cycle push or pop SHALL be discarded; flush has priority over hold.
REQ-026 Entries SHALL be stored only on push; storage contents need not be reset.

Reset
REQ-027 While reset=0, count=0, pointers=0, out_valid=0, out_data=RESET_VAL, in_ready=1, asynchronously and independent of clk.
REQ-028 Reset asserted mid-transfer SHALL discard all entries; the first edge after reset deasserts SHALL behave as an empty buffer.
REQ-029 Reset deassertion SHALL be synchronised by the integrating design; the block SHALL NOT add a synchroniser.

Verification
REQ-030 Defaults; push 0xA, 0xB on consecutive edges with out_ready=0 -> count=2, in_ready=0, out_data=0xA; third push 0xC is ignored.
REQ-031 Full (0xA, 0xB), out_ready=1 and in_valid=1 (0xC) together -> 0xA popped, 0xC not taken, count=1, out_data=0xB.
REQ-032 count=1 (0x5), push 0x6 and pop together -> count=1, out_data=0x6; repeat for 2*DEPTH+1 cycles to exercise wrap -> outputs match the input sequence exactly.
REQ-033 count=2, hold=1, out_ready=1 for 3 cycles -> out_data is stable, count=2; then flush=1 with hold=1 and in_valid=1 -> count=0, out_valid=0, out_data=RESET_VAL.
REQ-034 RESET_VAL=0xDEAD_BEEF, count=2; drive reset=0 between clock edges -> outputs reset immediately; after release, a push of 0x1 appears 1 cycle later.
REQ-035 Random in_valid/out_ready/hold/flush for 10k cycles against a scoreboard model -> no loss, duplication or reordering; count always matches the model.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Elastic FIFO pipeline stage with hold (output stall) and synchronous flush.
// Status and head payload are registered; storage is unreset.
module pipe_stage_buf #(
    parameter int unsigned     WIDTH     = 32,
    parameter int unsigned     DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       hold,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             push, pop;

    always_comb begin
        push        = in_valid && in_ready_q && !flush;
        pop         = out_valid_q && out_ready && !hold && !flush;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_data_d  = RESET_VAL;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end

        in_ready_d  = (count_d < CW'(DEPTH));
        out_valid_d = (count_d != '0);

        // A push into a buffer that is empty after this edge's pop becomes the head itself
        if (count_d == '0) begin
            out_data_d = RESET_VAL;
        end else if (push && (count_q == CW'(pop))) begin
            out_data_d = in_data;
        end else begin
            out_data_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= RESET_VAL;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign count     = count_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed-vector and scoreboard bench for pipe_stage_buf (WIDTH=32, DEPTH=2).
module tb_pipe_stage_buf;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] RV    = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, hold, flush;
    logic [31:0] in_data, out_data;
    logic [1:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_stage_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RV)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .hold(hold), .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        hld;
        logic        fl;
        logic [1:0]  e_cnt;
        logic        e_ov;
        logic        e_ir;
        logic [31:0] e_od;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(logic iv, logic [31:0] d, logic ordy, logic hld, logic fl,
                                logic [1:0] c, logic ov, logic ir, logic [31:0] od);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.hld = hld; v.fl = fl;
        v.e_cnt = c; v.e_ov = ov; v.e_ir = ir; v.e_od = od;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] c, input logic ov,
                           input logic ir, input logic [31:0] od);
        chk({tag, ".count"},     32'(count),     32'(c));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, ".in_ready"},  32'(in_ready),  32'(ir));
        chk({tag, ".out_data"},  out_data,       od);
    endtask

    task automatic drive(input logic iv, input logic [31:0] d, input logic ordy,
                         input logic hld, input logic fl);
        in_valid = iv; in_data = d; out_ready = ordy; hold = hld; flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] q[$];
    logic        m_push, m_pop;
    logic [31:0] exp_od;

    initial begin
        // directed table: fill/full, pop-while-full, empty underflow, push+pop, hold, flush
        vecs[0]  = mk(1, 32'hA,  0, 0, 0, 2'd1, 1, 1, 32'hA);
        vecs[1]  = mk(1, 32'hB,  0, 0, 0, 2'd2, 1, 0, 32'hA);
        vecs[2]  = mk(1, 32'hC,  0, 0, 0, 2'd2, 1, 0, 32'hA);
        vecs[3]  = mk(1, 32'hC,  1, 0, 0, 2'd1, 1, 1, 32'hB);
        vecs[4]  = mk(0, 32'h0,  1, 0, 0, 2'd0, 0, 1, RV);
        vecs[5]  = mk(0, 32'h0,  1, 1, 0, 2'd0, 0, 1, RV);
        vecs[6]  = mk(1, 32'h5,  1, 0, 0, 2'd1, 1, 1, 32'h5);
        vecs[7]  = mk(1, 32'h6,  1, 0, 0, 2'd1, 1, 1, 32'h6);
        vecs[8]  = mk(1, 32'h7,  1, 0, 0, 2'd1, 1, 1, 32'h7);
        vecs[9]  = mk(1, 32'h8,  1, 0, 0, 2'd1, 1, 1, 32'h8);
        vecs[10] = mk(1, 32'h9,  0, 0, 0, 2'd2, 1, 0, 32'h8);
        vecs[11] = mk(0, 32'h0,  1, 1, 0, 2'd2, 1, 0, 32'h8);
        vecs[12] = mk(0, 32'h0,  1, 1, 0, 2'd2, 1, 0, 32'h8);
        vecs[13] = mk(0, 32'h0,  1, 1, 0, 2'd2, 1, 0, 32'h8);
        vecs[14] = mk(1, 32'h55, 1, 1, 1, 2'd0, 0, 1, RV);
        vecs[15] = mk(1, 32'h11, 1, 1, 0, 2'd1, 1, 1, 32'h11);
        vecs[16] = mk(1, 32'h22, 1, 1, 0, 2'd2, 1, 0, 32'h11);
        vecs[17] = mk(0, 32'h0,  1, 0, 0, 2'd1, 1, 1, 32'h22);

        reset = 1'b0;
        drive(0, 32'h0, 0, 0, 0);
        #12;
        chk_all("reset", 2'd0, 0, 1, RV);
        @(negedge clk);
        reset = 1'b1;
        #1;

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].hld, vecs[i].fl);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_ov, vecs[i].e_ir, vecs[i].e_od);
        end

        // drain, then push+pop for 2*DEPTH+1 cycles across pointer wrap
        drive(0, 32'h0, 1, 0, 0);
        tick();
        chk_all("drain", 2'd0, 0, 1, RV);
        drive(1, 32'h100, 0, 0, 0);
        tick();
        chk_all("wrap_seed", 2'd1, 1, 1, 32'h100);
        for (int i = 0; i < 2 * DEPTH + 1; i++) begin
            drive(1, 32'h101 + 32'(i), 1, 0, 0);
            tick();
            chk_all($sformatf("wrap%0d", i), 2'd1, 1, 1, 32'h101 + 32'(i));
        end
        drive(0, 32'h0, 1, 0, 0);
        tick();
        chk_all("wrap_end", 2'd0, 0, 1, RV);

        // randomized traffic against a queue model
        q.delete();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 49) == 0));
            exp_od = (q.size() != 0) ? q[0] : RV;
            chk_all("rand", 2'(q.size()), q.size() != 0, q.size() < DEPTH, exp_od);
            m_push = in_valid && (q.size() < DEPTH) && !flush;
            m_pop  = (q.size() != 0) && out_ready && !hold && !flush;
            tick();
            if (flush) q.delete();
            else begin
                if (m_pop)  void'(q.pop_front());
                if (m_push) q.push_back(in_data);
            end
        end

        // asynchronous reset mid-transfer with a full buffer
        drive(0, 32'h0, 0, 0, 1);
        tick();
        drive(1, 32'hA1, 0, 0, 0);
        tick();
        drive(1, 32'hA2, 0, 0, 0);
        tick();
        drive(0, 32'h0, 0, 0, 0);
        chk_all("pre_reset", 2'd2, 1, 0, 32'hA1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_all("async_reset", 2'd0, 0, 1, RV);
        @(negedge clk);
        reset = 1'b1;
        drive(1, 32'h1, 0, 0, 0);
        tick();
        chk_all("post_reset", 2'd1, 1, 1, 32'h1);
        drive(0, 32'h0, 1, 0, 0);
        tick();
        chk_all("post_reset_pop", 2'd0, 0, 1, RV);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
